// File: rtl/uart_tx_sched.sv
// Two-client round-robin scheduler feeding a single 8N1 UART transmitter.
// Arbitration happens on every idle cycle and on the last stop-bit cycle, so frames can run back to back.
module uart_tx_sched #(
    parameter int CLKS_PER_BIT = 1736
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       tx,
    output logic       busy,
    output logic       src
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_ptr;
    logic        r_tx;
    logic        r_busy;
    logic        r_src;
    logic        r_ack0;
    logic        r_ack1;

    logic        w_bit_end;
    logic        w_arb_point;
    logic        w_any_req;
    logic        w_gnt;
    logic [7:0]  w_gnt_data;

    assign w_bit_end   = (r_cnt == LAST_CNT);
    assign w_arb_point = (r_state == IDLE) || ((r_state == STOP) && w_bit_end);
    assign w_any_req   = req0 | req1;
    // With both clients requesting the pointer decides; otherwise the lone requester wins.
    assign w_gnt       = (req0 & req1) ? r_ptr : req1;
    assign w_gnt_data  = w_gnt ? data1 : data0;

    always_ff @(posedge clk) begin
        // NOTE: the shift register is reset too, so a mid-frame reset leaves no stale byte behind.
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_ptr     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_src     <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            if (w_arb_point) begin
                r_cnt     <= '0;
                r_bit_idx <= '0;
                if (w_any_req) begin
                    r_state <= START;
                    r_shift <= w_gnt_data;
                    r_src   <= w_gnt;
                    r_ptr   <= ~w_gnt;
                    r_ack0  <= ~w_gnt;
                    r_ack1  <= w_gnt;
                    r_tx    <= 1'b0;
                    r_busy  <= 1'b1;
                end else begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            end else begin
                r_cnt <= w_bit_end ? '0 : r_cnt + 16'd1;
                if (w_bit_end) begin
                    case (r_state)
                        START: begin
                            r_state <= DATA;
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                        DATA: begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            if (r_bit_idx == 3'd7) begin
                                r_state <= STOP;
                                r_tx    <= 1'b1;
                            end else begin
                                r_tx    <= r_shift[0];
                                r_shift <= r_shift >> 1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign ack0 = r_ack0;
    assign ack1 = r_ack1;
    assign tx   = r_tx;
    assign busy = r_busy;
    assign src  = r_src;

endmodule
